decode_ctrl: RTL and testbench

Decode-stage controller for the core pipeline. It accepts fetched instructions over a valid/ready handshake and buffers them in a two-entry skid buffer. It generates each instruction's immediate and register fields, then presents one registered decode packet per cycle to the execute stage. It also implements pipeline flush and an optional load-use interlock.

---
 rtl/decode_ctrl_pkg.sv | 55 +++++
 rtl/decode_ctrl_immgen.sv | 28 ++
 rtl/decode_ctrl.sv | 149 ++++++++++++++
 tb/tb_decode_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg: shared definitions for the decode-stage controller.
//   - RV32 opcode constants used by immediate generation and hazard checks
//   - occupancy state encoding of the two-entry skid buffer
//   - decode packet field widths and the fixed-width field bundle
//   - helpers classifying which source registers an opcode reads
package decode_ctrl_pkg;

  localparam int unsigned DEC_XLEN = 32;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned OPC_W    = 7;

  localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_B     = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_S     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_I     = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  // Width-independent part of a decode packet; pc and imm are XLEN wide
  // and are carried alongside so the top can stay parameterised.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
  } dec_fields_t;

  function automatic dec_fields_t split_fields(input logic [INSTR_W-1:0] instr);
    dec_fields_t f;
    f.instr = instr;
    f.rd    = instr[11:7];
    f.rs1   = instr[19:15];
    f.rs2   = instr[24:20];
    return f;
  endfunction

  function automatic logic uses_rs1(input logic [OPC_W-1:0] opc);
    return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [OPC_W-1:0] opc);
    return (opc == OPC_R) || (opc == OPC_S) || (opc == OPC_B);
  endfunction

endpackage

// File: rtl/decode_ctrl_immgen.sv
// decode_ctrl_immgen: combinational immediate generator.
//   instr : in  INSTR_W  instruction word
//   imm   : out XLEN     formatted immediate (U/S/B/J, I-format for all else)
module decode_ctrl_immgen
  import decode_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = DEC_XLEN
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr[OPC_W-1:0])
      OPC_LUI, OPC_AUIPC: imm32 = {instr[31:12], 12'b0};
      OPC_S:   imm32 = 32'($signed({instr[31:25], instr[11:7]}));
      OPC_B:   imm32 = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      OPC_JAL: imm32 = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: imm32 = 32'($signed(instr[31:20]));
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: decode-stage controller with a two-entry skid buffer.
// Accepts instructions from fetch (valid/ready), attaches immediate and
// register fields, and presents one registered packet per cycle to execute.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_ifValid/o_ifReady   fetch handshake (o_ifReady registered)
//   i_ifInstr, i_ifPc     incoming instruction and its PC
//   o_exValid/i_exReady   execute handshake
//   o_exInstr, o_exPc, o_exImm, o_exRd, o_exRs1, o_exRs2  decode packet
//   i_flush               drop all buffered instructions
//   i_exLoadValid, i_exLoadRd  load in execute (load-use interlock)
// Build option: define DECODE_LOAD_USE_STALL_EN to enable the load-use
// interlock; otherwise i_exLoad* are ignored.
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = DEC_XLEN
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ifValid,
  input  logic [INSTR_W-1:0] i_ifInstr,
  input  logic [XLEN-1:0]    i_ifPc,
  output logic               o_ifReady,
  output logic               o_exValid,
  input  logic               i_exReady,
  output logic [INSTR_W-1:0] o_exInstr,
  output logic [XLEN-1:0]    o_exPc,
  output logic [XLEN-1:0]    o_exImm,
  output logic [REG_W-1:0]   o_exRd,
  output logic [REG_W-1:0]   o_exRs1,
  output logic [REG_W-1:0]   o_exRs2,
  input  logic               i_flush,
  input  logic               i_exLoadValid,
  input  logic [REG_W-1:0]   i_exLoadRd
);

  occ_state_t  state_q, state_d;
  logic        if_ready_q;
  logic        fetch_beat, exec_beat, out_valid, hazard;
  logic        load_out_in, load_out_skid, load_skid;

  dec_fields_t     in_fields, out_fields_q, skid_fields_q;
  logic [XLEN-1:0] in_imm, out_pc_q, out_imm_q, skid_pc_q, skid_imm_q;

  decode_ctrl_immgen #(.XLEN(XLEN)) u_immgen (
    .instr (i_ifInstr),
    .imm   (in_imm)
  );

  assign in_fields = split_fields(i_ifInstr);

  assign out_valid  = (state_q != OCC_EMPTY);
  assign o_exValid  = out_valid & ~hazard;
  assign fetch_beat = i_ifValid & if_ready_q;
  assign exec_beat  = o_exValid & i_exReady;
  assign o_ifReady  = if_ready_q;

`ifdef DECODE_LOAD_USE_STALL_EN
  logic [OPC_W-1:0] out_opc;
  assign out_opc = out_fields_q.instr[OPC_W-1:0];
  assign hazard  = i_exLoadValid && (i_exLoadRd != '0) &&
                   ((uses_rs1(out_opc) && (out_fields_q.rs1 == i_exLoadRd)) ||
                    (uses_rs2(out_opc) && (out_fields_q.rs2 == i_exLoadRd)));
`else
  logic unused_load;
  assign unused_load = ^{i_exLoadValid, i_exLoadRd};
  assign hazard      = 1'b0;
`endif

  // State register; ready is registered from the next state so it is
  // low exactly while the buffer is full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= OCC_EMPTY;
      if_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_ready_q <= (state_d != OCC_FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (fetch_beat) state_d = OCC_ONE;
      OCC_ONE: begin
        if (fetch_beat && !exec_beat)      state_d = OCC_FULL;
        else if (!fetch_beat && exec_beat) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (exec_beat) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
    if (i_flush) state_d = OCC_EMPTY;
  end

  // Register load enables; a flush suppresses loads so a fetch beat in
  // the flush cycle is consumed without being stored.
  always_comb begin
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (!i_flush) begin
      case (state_q)
        OCC_EMPTY: load_out_in = fetch_beat;
        OCC_ONE: begin
          load_out_in = fetch_beat & exec_beat;
          load_skid   = fetch_beat & ~exec_beat;
        end
        OCC_FULL:  load_out_skid = exec_beat;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_fields_q  <= '0;
      out_pc_q      <= '0;
      out_imm_q     <= '0;
      skid_fields_q <= '0;
      skid_pc_q     <= '0;
      skid_imm_q    <= '0;
    end else begin
      if (load_out_in) begin
        out_fields_q <= in_fields;
        out_pc_q     <= i_ifPc;
        out_imm_q    <= in_imm;
      end else if (load_out_skid) begin
        out_fields_q <= skid_fields_q;
        out_pc_q     <= skid_pc_q;
        out_imm_q    <= skid_imm_q;
      end
      if (load_skid) begin
        skid_fields_q <= in_fields;
        skid_pc_q     <= i_ifPc;
        skid_imm_q    <= in_imm;
      end
    end
  end

  assign o_exInstr = out_fields_q.instr;
  assign o_exRd    = out_fields_q.rd;
  assign o_exRs1   = out_fields_q.rs1;
  assign o_exRs2   = out_fields_q.rs2;
  assign o_exPc    = out_pc_q;
  assign o_exImm   = out_imm_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed, scoreboard-based bench for decode_ctrl.
// Expected packets are queued on every fetch beat and compared on every
// execute beat; directed checks cover latency, immediates, backpressure,
// load-use interlock, flush and asynchronous reset.
module tb_decode_ctrl;

  localparam logic [31:0] ADDI  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] SW    = 32'hFE20AE23; // sw x2,-4(x1)
  localparam logic [31:0] LUI   = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] ADD   = 32'h00218233; // add x4,x3,x2
  localparam logic [31:0] ADDIM = 32'hFFF08093; // addi x1,x1,-1

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ifValid, i_exReady, i_flush, i_exLoadValid;
  logic [31:0] i_ifInstr, i_ifPc;
  logic [4:0]  i_exLoadRd;
  logic        o_ifReady, o_exValid;
  logic [31:0] o_exInstr, o_exPc, o_exImm;
  logic [4:0]  o_exRd, o_exRs1, o_exRs2;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] stream [6] = '{32'h00001517, 32'h008000EF, 32'h000080E7,
                              32'hFE208CE3, 32'h00012183, ADDIM};

  always #5 clk = ~clk;

  decode_ctrl #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ifValid(i_ifValid), .i_ifInstr(i_ifInstr), .i_ifPc(i_ifPc),
    .o_ifReady(o_ifReady),
    .o_exValid(o_exValid), .i_exReady(i_exReady),
    .o_exInstr(o_exInstr), .o_exPc(o_exPc), .o_exImm(o_exImm),
    .o_exRd(o_exRd), .o_exRs1(o_exRs1), .o_exRs2(o_exRs2),
    .i_flush(i_flush), .i_exLoadValid(i_exLoadValid), .i_exLoadRd(i_exLoadRd)
  );

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'b0110111, 7'b0010111: return ins & 32'hFFFFF000;
      7'b0100011: return 32'($signed({ins[31:25], ins[11:7]}));
      7'b1100011: return 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      7'b1101111: return 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default:    return 32'($signed(ins[31:20]));
    endcase
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Samples handshakes at the falling edge, updates the scoreboard, then
  // returns 1 time unit after the following rising edge.
  task automatic clk_cycle();
    exp_t e;
    @(negedge clk);
    if (o_exValid && i_exReady) begin
      chk1("sb_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk32("ex_instr", o_exInstr, e.instr);
        chk32("ex_pc", o_exPc, e.pc);
        chk32("ex_imm", o_exImm, e.imm);
        chk32("ex_rd", 32'(o_exRd), 32'(e.instr[11:7]));
        chk32("ex_rs1", 32'(o_exRs1), 32'(e.instr[19:15]));
        chk32("ex_rs2", 32'(o_exRs2), 32'(e.instr[24:20]));
      end
    end
    if (i_flush) sb.delete();
    else if (i_ifValid && o_ifReady) begin
      e.instr = i_ifInstr;
      e.pc    = i_ifPc;
      e.imm   = ref_imm(i_ifInstr);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
    i_ifValid = 1'b1;
    i_ifInstr = ins;
    i_ifPc    = pc;
  endtask

  task automatic drain(input int budget);
    i_ifValid = 1'b0;
    i_exReady = 1'b1;
    for (int i = 0; i < budget && sb.size() != 0; i++) clk_cycle();
    chk32("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_ifValid = 1'b0; i_ifInstr = '0; i_ifPc = '0;
    i_exReady = 1'b1; i_flush = 1'b0; i_exLoadValid = 1'b0; i_exLoadRd = '0;
    clk_cycle(); clk_cycle();
    chk1("rst_exValid", o_exValid, 1'b0);
    chk1("rst_ifReady", o_ifReady, 1'b0);
    chk32("rst_instr", o_exInstr, 32'd0);
    chk32("rst_pc", o_exPc, 32'd0);
    chk32("rst_imm", o_exImm, 32'd0);
    chk32("rst_regs", 32'({o_exRd, o_exRs1, o_exRs2}), 32'd0);
    rst_n = 1'b1;
    #1 chk1("ifReady_before_edge", o_ifReady, 1'b0);
    clk_cycle();
    chk1("ifReady_after_release", o_ifReady, 1'b1);
    chk1("exValid_idle", o_exValid, 1'b0);

    // Latency and immediate formats
    fetch(ADDI, 32'h100); clk_cycle(); i_ifValid = 1'b0;
    chk1("addi_latency", o_exValid, 1'b1);
    chk32("addi_imm", o_exImm, 32'h00000005);
    chk32("addi_rd", 32'(o_exRd), 32'd1);
    chk32("addi_rs1", 32'(o_exRs1), 32'd0);
    fetch(SW, 32'h104); clk_cycle();
    chk32("sw_imm", o_exImm, 32'hFFFFFFFC);
    chk32("sw_rs1", 32'(o_exRs1), 32'd1);
    chk32("sw_rs2", 32'(o_exRs2), 32'd2);
    fetch(LUI, 32'h108); clk_cycle();
    chk32("lui_imm", o_exImm, 32'h12345000);
    for (int i = 0; i < 6; i++) begin
      fetch(stream[i], 32'h10C + 32'(i) * 4);
      clk_cycle();
      chk1("stream_exValid", o_exValid, 1'b1);
      chk1("stream_ifReady", o_ifReady, 1'b1);
    end
    drain(8);

    // Backpressure: two accepted, third held upstream
    i_exReady = 1'b0;
    fetch(32'h00100113, 32'h200); clk_cycle();
    fetch(32'h00200193, 32'h204); clk_cycle();
    chk1("bp_full_ifReady", o_ifReady, 1'b0);
    fetch(32'h00300213, 32'h208); clk_cycle();
    chk1("bp_held_ifReady", o_ifReady, 1'b0);
    chk1("bp_exValid", o_exValid, 1'b1);
    chk32("bp_out_stable", o_exInstr, 32'h00100113);
    chk32("bp_sb_depth", 32'(sb.size()), 32'd2);
    i_exReady = 1'b1;
    clk_cycle(); clk_cycle();
    drain(8);

    // Load-use on rs1 of add x4,x3,x2
    i_exLoadValid = 1'b1; i_exLoadRd = 5'd3;
    fetch(ADD, 32'h300); clk_cycle(); i_ifValid = 1'b0;
`ifdef DECODE_LOAD_USE_STALL_EN
    chk1("lu_stall0", o_exValid, 1'b0);
    clk_cycle();
    chk1("lu_stall1", o_exValid, 1'b0);
    chk32("lu_hold", o_exInstr, ADD);
    i_exLoadValid = 1'b0;
    #1 chk1("lu_release", o_exValid, 1'b1);
`else
    chk1("lu_nostall", o_exValid, 1'b1);
`endif
    chk32("lu_instr", o_exInstr, ADD);
    drain(8);
    i_exLoadValid = 1'b1; i_exLoadRd = 5'd5;
    fetch(ADD, 32'h304); clk_cycle(); i_ifValid = 1'b0;
    chk1("lu_nomatch", o_exValid, 1'b1);
    drain(8);
    i_exLoadValid = 1'b0;

    // Flush in FULL with a pending fetch
    i_exReady = 1'b0;
    fetch(32'h00A00513, 32'h400); clk_cycle();
    fetch(32'h00B00593, 32'h404); clk_cycle();
    fetch(32'h00C00613, 32'h408); i_flush = 1'b1; clk_cycle();
    i_flush = 1'b0;
    chk1("flush_exValid", o_exValid, 1'b0);
    chk1("flush_ifReady", o_ifReady, 1'b1);
    fetch(32'h00D00693, 32'h40C); clk_cycle(); i_ifValid = 1'b0;
    chk32("flush_first_after", o_exInstr, 32'h00D00693);
    drain(8);

    // Flush in ONE with concurrent fetch and execute beats
    i_exReady = 1'b0;
    fetch(32'h00E00713, 32'h500); clk_cycle();
    i_exReady = 1'b1; i_flush = 1'b1;
    fetch(32'h00F00793, 32'h504); clk_cycle();
    i_flush = 1'b0; i_ifValid = 1'b0;
    chk1("flush1_exValid", o_exValid, 1'b0);
    chk1("flush1_ifReady", o_ifReady, 1'b1);
    clk_cycle();
    chk1("flush1_dropped", o_exValid, 1'b0);

    // Asynchronous reset while FULL
    i_exReady = 1'b0;
    fetch(32'h01000813, 32'h600); clk_cycle();
    fetch(32'h01100893, 32'h604); clk_cycle();
    i_ifValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_exValid", o_exValid, 1'b0);
    chk1("arst_ifReady", o_ifReady, 1'b0);
    chk32("arst_instr", o_exInstr, 32'd0);
    chk32("arst_imm", o_exImm, 32'd0);
    chk32("arst_pc", o_exPc, 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("arst_resume_ifReady", o_ifReady, 1'b1);
    chk1("arst_resume_exValid", o_exValid, 1'b0);
    i_exReady = 1'b1;
    fetch(ADDI, 32'h700); clk_cycle(); i_ifValid = 1'b0;
    chk32("arst_resume_instr", o_exInstr, ADDI);
    drain(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
